lcd_sequencer: RTL and testbench

Front-end controller for the HD44780-style `Display` write engine. After power-up it issues the fixed LCD init command list, then on each `Start` pulse streams a 32-character message (two 16-character lines) from an external message buffer. It drives the engine's request inputs and consumes its completion pulses, one write at a time, and exposes a simple `Ready`/`Done`/`Error` status to the top level.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_init_rom.sv | 11 +
 rtl/lcd_sequencer.sv | 84 ++++++++
 tb/tb_lcd_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer state encoding and HD44780 command constants
package lcd_pkg;
    typedef enum logic [2:0] {
        POWERUP,
        INIT_REQ,
        INIT_GAP,
        IDLE,
        CHAR_REQ,
        CHAR_GAP
    } state_t;

    localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_LINE2_ADDR = 8'h40;
endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: init command list indexed by position in the power-up sequence
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [1:0] idx,
    output logic [7:0] cmd
);
    always_comb cmd = idx == 2'd0 ? LCD_FUNC_SET :
                      idx == 2'd1 ? LCD_DISP_ON  :
                      idx == 2'd2 ? LCD_ENTRY    : LCD_CLEAR;
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: runs the LCD init list after power-up, then streams 2-line messages to the write engine
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 1500000,
    parameter int LINE_LEN       = 16,
    parameter int TIMEOUT        = 4000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] MsgData,
    output logic [4:0] MsgAddr,
    input  logic       InitEscrito,
    input  logic       CharEscrito,
    output logic [7:0] DatoInit,
    output logic [7:0] DatoLCD,
    output logic       Init,
    output logic       Ejecutar,
    output logic       Linea2,
    output logic       Cuenta,
    output logic       Ready,
    output logic       Done,
    output logic       Error
);
    state_t      state, state_nxt;
    logic [21:0] cnt;
    logic [1:0]  idx, idx_nxt;
    logic [7:0]  rom_cmd;
    logic        tmo, tmo_hit, line_end;

    lcd_init_rom u_rom (.idx(idx_nxt), .cmd(rom_cmd));

    // MsgAddr advances on entry to CHAR_GAP so MsgData is already valid when the next request is registered
    always_comb begin
        tmo       = cnt == 22'(TIMEOUT - 1);
        tmo_hit   = tmo && ((state == INIT_REQ && !InitEscrito) || (state == CHAR_REQ && !CharEscrito));
        idx_nxt   = state == POWERUP ? 2'd0 : state == INIT_GAP ? idx + 2'd1 : idx;
        line_end  = MsgAddr == 5'(LINE_LEN - 1);
        state_nxt = state;
        case (state)
            POWERUP:  state_nxt = cnt == 22'(POWERUP_CYCLES - 1) ? INIT_REQ : POWERUP;
            INIT_REQ: state_nxt = InitEscrito ? INIT_GAP : tmo ? POWERUP : INIT_REQ;
            INIT_GAP: state_nxt = idx == 2'd3 ? IDLE : INIT_REQ;
            IDLE:     state_nxt = Start ? CHAR_REQ : IDLE;
            CHAR_REQ: state_nxt = CharEscrito ? CHAR_GAP : tmo ? IDLE : CHAR_REQ;
            CHAR_GAP: state_nxt = MsgAddr == 5'(2 * LINE_LEN) ? IDLE : CHAR_REQ;
            default:  state_nxt = POWERUP;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= POWERUP;
            cnt      <= '0;
            idx      <= '0;
            MsgAddr  <= '0;
            DatoInit <= '0;
            DatoLCD  <= '0;
            Init     <= 1'b0;
            Ejecutar <= 1'b0;
            Linea2   <= 1'b0;
            Cuenta   <= 1'b0;
            Ready    <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= state_nxt == state ? cnt + 22'd1 : '0;
            idx      <= idx_nxt;
            MsgAddr  <= state_nxt == IDLE ? '0 :
                        state == CHAR_REQ && state_nxt == CHAR_GAP ? MsgAddr + 5'd1 : MsgAddr;
            DatoInit <= state_nxt == INIT_REQ ? rom_cmd : DatoInit;
            DatoLCD  <= state != CHAR_REQ && state_nxt == CHAR_REQ ? MsgData : DatoLCD;
            Init     <= state_nxt == INIT_REQ;
            Ejecutar <= state_nxt == CHAR_REQ;
            Linea2   <= state_nxt == CHAR_REQ && line_end;
            Cuenta   <= state_nxt == CHAR_REQ && line_end;
            Ready    <= state_nxt == IDLE;
            Done     <= state == CHAR_GAP && state_nxt == IDLE;
            Error    <= tmo_hit || (Error && !(state == IDLE && Start));
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: random-latency engine model with a transaction-level reference for init and message writes
module tb_lcd_sequencer;
    localparam int P = 40;
    localparam int T = 300;
    localparam int L = 16;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
        logic       l2;
        logic       ct;
    } ch_t;

    logic        clk, Reset, Start, InitEscrito, CharEscrito;
    logic [7:0]  MsgData, DatoInit, DatoLCD;
    logic [4:0]  MsgAddr;
    logic        Init, Ejecutar, Linea2, Cuenta, Ready, Done, Error;
    logic [27:0] outs;
    logic [7:0]  msg_mem [32];
    logic [7:0]  init_exp [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [7:0]  init_q [$];
    ch_t         char_q [$];
    ch_t         cur, h_char;
    logic [7:0]  h_init;
    logic        p_init, p_ej, p_done, withhold, rnd;
    int          n_cmp, n_bad, cyc, rel, first_init, done_cnt, ack_cnt, ack_delay, hi;
    logic [4:0]  a_saved;

    lcd_sequencer #(.POWERUP_CYCLES(P), .LINE_LEN(L), .TIMEOUT(T)) dut (
        .Clk(clk), .Reset(Reset), .Start(Start), .MsgData(MsgData), .MsgAddr(MsgAddr),
        .InitEscrito(InitEscrito), .CharEscrito(CharEscrito), .DatoInit(DatoInit), .DatoLCD(DatoLCD),
        .Init(Init), .Ejecutar(Ejecutar), .Linea2(Linea2), .Cuenta(Cuenta),
        .Ready(Ready), .Done(Done), .Error(Error)
    );

    assign MsgData = msg_mem[MsgAddr];
    assign outs = {MsgAddr, DatoInit, DatoLCD, Init, Ejecutar, Linea2, Cuenta, Ready, Done, Error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one cycle of the engine model: acks a held request after ack_delay cycles unless withheld
    task automatic step();
        @(negedge clk);
        cyc++;
        InitEscrito = 1'b0;
        CharEscrito = 1'b0;
        if ((Init || Ejecutar) && !withhold) begin
            if (ack_cnt >= ack_delay) begin
                InitEscrito = Init;
                CharEscrito = Ejecutar;
                ack_cnt = 0;
                ack_delay = rnd ? int'($urandom_range(2, 25)) : 20;
            end else ack_cnt++;
        end else ack_cnt = 0;
    endtask

    task automatic fill_msg();
        string hello = "HELLO";
        for (int i = 0; i < 32; i++)
            msg_mem[i] = i < 5 ? hello[i] : 8'($urandom_range(32, 126));
    endtask

    task automatic check_chars(input int n);
        for (int i = 0; i < n && i < char_q.size(); i++) begin
            chk("char_addr", 32'(char_q[i].a), 32'(i));
            chk("char_data", 32'(char_q[i].d), 32'(msg_mem[i]));
            chk("char_linea2", 32'(char_q[i].l2), 32'(i == L - 1));
            chk("char_cuenta", 32'(char_q[i].ct), 32'(i == L - 1));
        end
    endtask

    task automatic check_init();
        for (int i = 0; i < P + 500 && !Ready; i++) step();
        chk("init_ready", 32'(Ready), 1);
        chk("init_count", 32'(init_q.size()), 4);
        for (int i = 0; i < 4 && i < init_q.size(); i++) chk("init_cmd", 32'(init_q[i]), 32'(init_exp[i]));
        chk("powerup_len", 32'(first_init - rel >= P - 1 && first_init - rel <= P + 1), 1);
        chk("init_no_chars", 32'(char_q.size()), 0);
    endtask

    initial begin
        p_init = 1'b0;
        p_ej = 1'b0;
        p_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (Init && !p_init) begin
                if (init_q.size() == 0) first_init = cyc;
                init_q.push_back(DatoInit);
                h_init = DatoInit;
            end else if (Init) chk("init_hold", 32'(DatoInit), 32'(h_init));
            cur = '{a: MsgAddr, d: DatoLCD, l2: Linea2, ct: Cuenta};
            if (Ejecutar && !p_ej) begin
                char_q.push_back(cur);
                h_char = cur;
            end else if (Ejecutar) chk("char_hold", 32'(cur), 32'(h_char));
            if (Done) begin
                done_cnt++;
                chk("done_width", 32'(p_done), 0);
                chk("done_ready", 32'(Ready), 1);
            end
            p_init = Init;
            p_ej = Ejecutar;
            p_done = Done;
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; InitEscrito = 1'b0; CharEscrito = 1'b0;
        withhold = 1'b0; rnd = 1'b0; ack_cnt = 0; ack_delay = 20;
        fill_msg();
        repeat (3) step();
        chk("reset_outs", 32'(outs), 0);
        Reset = 1'b0;
        rel = cyc;
        repeat (10) step();
        Start = 1'b1; step(); Start = 1'b0;
        check_init();
        chk("init_error", 32'(Error), 0);

        rnd = 1'b1;
        fill_msg();
        char_q.delete();
        done_cnt = 0;
        Start = 1'b1; step(); Start = 1'b0;
        chk("start_req", 32'(Ejecutar), 1);
        chk("start_addr", 32'(MsgAddr), 0);
        chk("start_busy", 32'(Ready), 0);
        for (int i = 0; i < 2000 && char_q.size() < 10; i++) step();
        withhold = 1'b1;
        step();
        for (int i = 0; i < 100 && !Ejecutar; i++) step();
        chk("stray_setup", 32'(Ejecutar), 1);
        a_saved = MsgAddr;
        InitEscrito = 1'b1; step();
        chk("stray_init_addr", 32'(MsgAddr), 32'(a_saved));
        chk("stray_init_req", 32'(Ejecutar), 1);
        Start = 1'b1; step(); Start = 1'b0;
        chk("mid_start_addr", 32'(MsgAddr), 32'(a_saved));
        chk("mid_start_req", 32'(Ejecutar), 1);
        withhold = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
        repeat (3) step();
        chk("msg_done", 32'(done_cnt), 1);
        chk("msg_len", 32'(char_q.size()), 32);
        check_chars(32);
        chk("msg_ready", 32'(Ready), 1);

        CharEscrito = 1'b1; step();
        chk("spur_ready", 32'(Ready), 1);
        chk("spur_req", 32'(Ejecutar), 0);
        chk("spur_addr", 32'(MsgAddr), 0);
        repeat (3) step();
        chk("spur_done", 32'(done_cnt), 1);

        fill_msg();
        char_q.delete();
        done_cnt = 0;
        Start = 1'b1; step(); Start = 1'b0;
        for (int i = 0; i < 3000 && !(Ejecutar && MsgAddr == 5'd7); i++) step();
        chk("tmo_setup", 32'(Ejecutar && MsgAddr == 5'd7), 1);
        withhold = 1'b1;
        hi = 1;
        for (int i = 0; i < T + 50 && !Error; i++) begin
            step();
            if (Ejecutar) hi++;
        end
        chk("tmo_error", 32'(Error), 1);
        chk("tmo_len", 32'(hi >= T - 1 && hi <= T + 1), 1);
        chk("tmo_req", 32'(Ejecutar), 0);
        chk("tmo_ready", 32'(Ready), 1);
        repeat (5) step();
        chk("tmo_no_done", 32'(done_cnt), 0);
        chk("tmo_sticky", 32'(Error), 1);
        chk("tmo_chars", 32'(char_q.size()), 8);
        check_chars(8);
        withhold = 1'b0;

        char_q.delete();
        Start = 1'b1; step(); Start = 1'b0;
        chk("err_clear", 32'(Error), 0);
        chk("restart_req", 32'(Ejecutar), 1);
        for (int i = 0; i < 3000 && !(Ejecutar && MsgAddr == 5'd20); i++) step();
        chk("rst_setup", 32'(Ejecutar && MsgAddr == 5'd20), 1);
        check_chars(21);
        Reset = 1'b1; step();
        chk("rst_mid_outs", 32'(outs), 0);
        Reset = 1'b0;
        rel = cyc;
        init_q.delete();
        char_q.delete();
        check_init();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
